stepper_move_ctrl: RTL

Motion-profile generator that sits directly upstream of the stepper coil sequencer. It turns one move command into a train of single-cycle step strobes plus a held direction bit: a move is a step count and a direction. The strobes follow a linear trapezoidal period ramp: accelerate, cruise, then decelerate symmetrically. The sequencer consumes `step_en` as its enable and `step_dir` as its direction, advancing one phase per strobe.

---
 rtl/stepper_pkg.sv | 18 +
 rtl/step_timer.sv | 43 ++++
 rtl/stepper_move_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper motion path.
// Direction encoding is also consumed by the coil sequencer.
package stepper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEL,
    ST_CRUISE,
    ST_DECEL,
    ST_DONE
  } move_state_t;

  localparam int PER_FLOOR = 2;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter: load N-1 and expire fires N cycles after the load edge.
// Goes inactive after expiring until the next load.
module step_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PER_W-1:0] load_val,
  output logic             expire
);

  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = load_val;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - PER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign expire = active_q && (cnt_q == '0);

endmodule

// File: rtl/stepper_move_ctrl.sv
// Trapezoidal step-strobe generator: one move command in, a ramped strobe train out.
// Strobe decisions are made in the timer's expire cycle so step_en lands on the interval boundary.
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] steps,
  input  logic [PER_W-1:0] per_start,
  input  logic [PER_W-1:0] per_min,
  input  logic [PER_W-1:0] per_dec,
  output logic             step_en,
  output logic             step_dir,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  move_state_t      state_q, state_d;
  logic [CNT_W-1:0] steps_left_q, steps_left_d;
  logic [CNT_W-1:0] ramp_q, ramp_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] ps_q, ps_d;
  logic [PER_W-1:0] pm_q, pm_d;
  logic [PER_W-1:0] pd_q, pd_d;
  logic             dir_q, dir_d;
  logic             step_en_q, step_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [PER_W-1:0] ps_in, pm_raw, pm_in;
  logic [PER_W:0]   per_sum, per_diff;
  logic [CNT_W-1:0] sl_new;
  logic [CNT_W:0]   ramp_p1;
  logic             timer_load;
  logic [PER_W-1:0] timer_val;
  logic             expire;

  step_timer #(.PER_W(PER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (expire)
  );

  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    ramp_d       = ramp_q;
    period_d     = period_q;
    ps_d         = ps_q;
    pm_d         = pm_q;
    pd_d         = pd_q;
    dir_d        = dir_q;
    step_en_d    = 1'b0;
    timer_load   = 1'b0;
    timer_val    = '0;
    ramp_p1      = '0;

    ps_in    = (per_start < PER_W'(PER_FLOOR)) ? PER_W'(PER_FLOOR) : per_start;
    pm_raw   = (per_min < PER_W'(PER_FLOOR)) ? PER_W'(PER_FLOOR) : per_min;
    pm_in    = (pm_raw > ps_in) ? ps_in : pm_raw;
    per_sum  = {1'b0, period_q} + {1'b0, pd_q};
    per_diff = {1'b0, period_q} - {1'b0, pd_q};
    sl_new   = steps_left_q - CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d    = dir_in;
          ps_d     = ps_in;
          pm_d     = pm_in;
          pd_d     = per_dec;
          ramp_d   = '0;
          period_d = ps_in;
          if (steps == '0) begin
            state_d      = ST_DONE;
            steps_left_d = '0;
          end else begin
            state_d      = (pm_in == ps_in) ? ST_CRUISE : ST_ACCEL;
            step_en_d    = 1'b1;
            steps_left_d = steps - CNT_W'(1);
            if (steps != CNT_W'(1)) begin
              timer_load = 1'b1;
              timer_val  = ps_in - PER_W'(1);
            end
          end
        end
      end

      ST_ACCEL, ST_CRUISE, ST_DECEL: begin
        // steps_left reads 0 only in the cycle of the final strobe
        if (steps_left_q == '0) begin
          state_d = ST_DONE;
        end else begin
          if (expire) begin
            step_en_d    = 1'b1;
            steps_left_d = sl_new;
            if (sl_new != '0) begin
              if (sl_new <= ramp_q) begin
                state_d  = ST_DECEL;
                period_d = (per_sum > {1'b0, ps_q}) ? ps_q : per_sum[PER_W-1:0];
                if (ramp_q != '0) begin
                  ramp_d = ramp_q - CNT_W'(1);
                end
              end else if (state_q == ST_ACCEL) begin
                period_d = (per_diff[PER_W] || (per_diff[PER_W-1:0] < pm_q)) ?
                           pm_q : per_diff[PER_W-1:0];
                ramp_d   = ramp_q + CNT_W'(1);
                if (period_d == pm_q) begin
                  state_d = ST_CRUISE;
                end
              end
              timer_load = 1'b1;
              timer_val  = period_d - PER_W'(1);
            end
          end
          // Stop only trims the remaining count; the strobe rule then ramps down
          ramp_p1 = {1'b0, ramp_d} + (CNT_W+1)'(1);
          if (stop && (state_d == ST_ACCEL || state_d == ST_CRUISE) &&
              (steps_left_d != '0) && ({1'b0, steps_left_d} > ramp_p1)) begin
            steps_left_d = ramp_p1[CNT_W-1:0];
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ACCEL) || (state_d == ST_CRUISE) || (state_d == ST_DECEL);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      steps_left_q <= '0;
      ramp_q       <= '0;
      period_q     <= '0;
      ps_q         <= '0;
      pm_q         <= '0;
      pd_q         <= '0;
      dir_q        <= DIR_CW;
      step_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      ramp_q       <= ramp_d;
      period_q     <= period_d;
      ps_q         <= ps_d;
      pm_q         <= pm_d;
      pd_q         <= pd_d;
      dir_q        <= dir_d;
      step_en_q    <= step_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign step_en    = step_en_q;
  assign step_dir   = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = steps_left_q;

endmodule
